// File: rtl/cmp_debounce_pkg.sv
// Shared types for the comparator debouncer: FSM states, sample classes
// and the comparator-result classifier.
package cmp_debounce_pkg;

    typedef enum logic [1:0] {
        S_BELOW,
        S_RISE,
        S_ABOVE,
        S_FALL
    } state_t;

    typedef enum logic [1:0] {
        CLS_LT,
        CLS_EQ,
        CLS_GT
    } sample_class_t;

    // Both inputs high is a comparator fault; it falls into the dead band.
    function automatic sample_class_t classify(input logic eq, input logic gt);
        if (eq)
            return CLS_EQ;
        else if (gt)
            return CLS_GT;
        else
            return CLS_LT;
    endfunction

endpackage

// File: rtl/cmp_debounce_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/cmp_debounce.sv
// Debounced, hysteretic "above threshold" level from comparator results,
// with rise/fall event pulses, a saturating rise counter and a sticky fault flag.
module cmp_debounce
    import cmp_debounce_pkg::*;
#(
    parameter int DEBOUNCE_N = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             comp_equal,
    input  logic             comp_greater,
    input  logic             cnt_clr,
    output logic             above,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic             proto_err
);

    localparam int RUN_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_N);

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    sample_class_t    cls;
    logic             above_d, rise_d, fall_d;

    assign cls     = classify(comp_equal, comp_greater);
    assign run_inc = run_q + RUN_W'(1);

    // State register; outputs are registered alongside so they change with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_BELOW;
            run_q      <= '0;
            above      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            above      <= above_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

    // Next state: EQ samples and invalid cycles freeze both state and run.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (sample_valid) begin
            case (state_q)
                S_BELOW: begin
                    if (cls == CLS_GT) begin
                        state_d = S_RISE;
                        run_d   = RUN_W'(1);
                    end else begin
                        run_d = '0;
                    end
                end
                S_RISE: begin
                    if (cls == CLS_GT) begin
                        if (run_inc == RUN_LAST) begin
                            state_d = S_ABOVE;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (cls == CLS_LT) begin
                        state_d = S_BELOW;
                        run_d   = '0;
                    end
                end
                S_ABOVE: begin
                    if (cls == CLS_LT) begin
                        state_d = S_FALL;
                        run_d   = RUN_W'(1);
                    end else begin
                        run_d = '0;
                    end
                end
                S_FALL: begin
                    if (cls == CLS_LT) begin
                        if (run_inc == RUN_LAST) begin
                            state_d = S_BELOW;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (cls == CLS_GT) begin
                        state_d = S_ABOVE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = S_BELOW;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Output decode; a bounce back from S_FALL to S_ABOVE is not a rise event.
    always_comb begin
        rise_d  = (state_q == S_RISE) && (state_d == S_ABOVE);
        fall_d  = (state_q == S_FALL) && (state_d == S_BELOW);
        above_d = (state_d == S_ABOVE) || (state_d == S_FALL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            proto_err <= 1'b0;
        else if (cnt_clr)
            proto_err <= 1'b0;
        else if (sample_valid && comp_equal && comp_greater)
            proto_err <= 1'b1;
    end

    // Fed with the pre-register pulse so the count lands in the pulse cycle.
    sat_counter #(
        .W (CNT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rise_d),
        .clr   (cnt_clr),
        .cnt   (event_count)
    );

endmodule

// File: tb/tb_cmp_debounce.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, monitor pops and compares.
module tb_cmp_debounce;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int LT = 0, EQ = 1, GT = 2, BOTH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic          comp_equal = 1'b0;
    logic          comp_greater = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          above, rise_pulse, fall_pulse, proto_err;
    logic [CW-1:0] event_count;

    cmp_debounce #(
        .DEBOUNCE_N (N),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .comp_equal   (comp_equal),
        .comp_greater (comp_greater),
        .cnt_clr      (cnt_clr),
        .above        (above),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .event_count  (event_count),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic above;
        logic rise;
        logic fall;
        int   cnt;
        logic perr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: level flips after N non-EQ samples in a row pointing away from it.
    bit m_level  = 0;
    int m_streak = 0;
    int m_cnt    = 0;
    bit m_perr   = 0;

    task automatic drive(input bit r, input bit v, input bit eq, input bit gt, input bit clr);
        exp_t e;
        @(negedge clk);
        rst_n        = r;
        sample_valid = v;
        comp_equal   = eq;
        comp_greater = gt;
        cnt_clr      = clr;
        e.rise = 0;
        e.fall = 0;
        if (!r) begin
            m_level = 0; m_streak = 0; m_cnt = 0; m_perr = 0;
        end else begin
            if (v) begin
                if (eq && gt) m_perr = 1;
                if (!eq) begin
                    if (gt != m_level) m_streak++;
                    else               m_streak = 0;
                    if (m_streak == N) begin
                        m_level  = !m_level;
                        m_streak = 0;
                        if (m_level) begin
                            e.rise = 1;
                            if (m_cnt < (1 << CW) - 1) m_cnt++;
                        end else begin
                            e.fall = 1;
                        end
                    end
                end
            end
            if (clr) begin
                m_cnt  = 0;
                m_perr = 0;
            end
        end
        e.above = m_level;
        e.cnt   = m_cnt;
        e.perr  = m_perr;
        sb.push_back(e);
    endtask

    task automatic s(input int c, input bit v = 1, input bit clr = 0);
        drive(1'b1, v, (c == EQ) || (c == BOTH), (c == GT) || (c == BOTH), clr);
    endtask

    task automatic rep(input int c, input int n);
        for (int i = 0; i < n; i++) s(c);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so the entry pushed before an edge is compared after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("above",       int'(above),       int'(e.above));
                chk("rise_pulse",  int'(rise_pulse),  int'(e.rise));
                chk("fall_pulse",  int'(fall_pulse),  int'(e.fall));
                chk("event_count", int'(event_count), e.cnt);
                chk("proto_err",   int'(proto_err),   int'(e.perr));
                chk("pulse_excl",  int'(rise_pulse & fall_pulse), 0);
            end
        end
    end

    initial begin
        int pref, c;
        bit v, clr, r;

        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1);

        // basic rise
        rep(GT, 4);
        s(LT, 0);
        // fall with bounce-back
        rep(LT, 2); s(GT); rep(LT, 4);
        // debounce abort
        rep(GT, 3); s(LT); rep(GT, 4);
        rep(LT, 4);
        // EQ dead band and invalid gaps
        rep(GT, 2); rep(EQ, 2); s(GT, 0); s(LT, 0); s(EQ, 0); rep(GT, 2);
        rep(LT, 4);
        // saturation: events 4 and 5
        rep(GT, 4); rep(LT, 4);
        rep(GT, 4); rep(LT, 4);
        // sixth rise with simultaneous clear
        rep(GT, 3); s(GT, 1, 1);
        s(EQ, 0);
        // protocol error, sticky, treated as EQ
        rep(LT, 2); s(BOTH); rep(EQ, 2); rep(LT, 2);
        // reset mid-run
        rep(GT, 3);
        drive(0, 1, 0, 1, 0);
        rep(GT, 3); s(EQ); s(GT);

        // randomized phase with a drifting preferred class
        pref = GT;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) pref = ($urandom_range(1) != 0) ? GT : LT;
            if ($urandom_range(49) == 0)      c = BOTH;
            else if ($urandom_range(9) < 7)   c = pref;
            else                              c = int'($urandom_range(2));
            v   = ($urandom_range(3) != 0);
            clr = ($urandom_range(39) == 0);
            r   = ($urandom_range(149) != 0);
            drive(r, v, (c == EQ) || (c == BOTH), (c == GT) || (c == BOTH), clr);
        end

        s(EQ, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
